// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared bus widths, IO window addresses and address decode.
package mem_responder_pkg;
  localparam int ADDR_W = 32;
  localparam int BYTE_W = 8;
  localparam logic [1:0] IO_WIN = 2'b11;
  localparam logic [ADDR_W-1:0] IO_TX_ADDR = 32'h0003_0000;
  localparam logic [ADDR_W-1:0] IO_HALT_ADDR = 32'h0003_0004;
  typedef enum logic [1:0] {SEL_RAM, SEL_TX, SEL_HALT, SEL_IO_OTHER} sel_e;
  function automatic sel_e decode(input logic [ADDR_W-1:0] a);
    return (a[17:16] != IO_WIN) ? SEL_RAM :
           (a == IO_TX_ADDR)    ? SEL_TX  :
           (a == IO_HALT_ADDR)  ? SEL_HALT : SEL_IO_OTHER;
  endfunction
endpackage

// File: rtl/io_tx_fifo.sv
// io_tx_fifo: synchronous transmit FIFO with registered almost-full flag; pushes into a full FIFO are dropped.
module io_tx_fifo
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     push,
  input  logic [BYTE_W-1:0]        din,
  input  logic                     pop_ready,
  input  logic [$clog2(DEPTH):0]   thresh,
  output logic [BYTE_W-1:0]        dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  logic [BYTE_W-1:0] buf_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic almost_full_q, almost_full_d, do_push, do_pop;
  always_comb begin
    valid = en && (count_q != '0);
    do_pop = valid && pop_ready;
    do_push = en && push && (count_q != CNT_FULL);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    almost_full_d = en ? (count_d >= thresh) : almost_full_q;
    dout = buf_q[rd_ptr_q];
    count = count_q;
    almost_full = almost_full_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      almost_full_q <= almost_full_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && do_push) buf_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte RAM with one-cycle read latency plus IO window feeding a transmit FIFO and halt pulse.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] call_addr,
  input  logic              is_write,
  input  logic [BYTE_W-1:0] write_data,
  output logic [BYTE_W-1:0] ret_data,
  output logic              io_buffer_full,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              sim_end,
  output logic              io_overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_THRESH = CW'(FIFO_DEPTH - 2);
  logic [BYTE_W-1:0] ram_q [2**RAM_ADDR_BITS];
  logic [BYTE_W-1:0] ret_data_q, ret_data_d;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic [CW-1:0] fifo_count;
  logic sim_end_q, sim_end_d, io_overflow_q, io_overflow_d, push, ram_we;
  sel_e sel;
  always_comb begin
    sel = decode(call_addr);
    ram_addr = call_addr[RAM_ADDR_BITS-1:0];
    ram_we = rdy && is_write && (sel == SEL_RAM);
    push = rdy && is_write && (sel == SEL_TX);
    ret_data_d = !rdy ? ret_data_q : (sel == SEL_RAM) ? ram_q[ram_addr] : '0;
    sim_end_d = rdy && is_write && (sel == SEL_HALT);
    io_overflow_d = io_overflow_q || (push && (fifo_count == CNT_FULL));
    ret_data = ret_data_q;
    sim_end = sim_end_q && rdy;
    io_overflow = io_overflow_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      ret_data_q <= '0;
      sim_end_q <= 1'b0;
      io_overflow_q <= 1'b0;
    end else begin
      ret_data_q <= ret_data_d;
      sim_end_q <= sim_end_d;
      io_overflow_q <= io_overflow_d;
    end
  end
  // RAM keeps its contents across reset; only a write on a reset edge is suppressed.
  always_ff @(posedge clk) begin
    if (rst && ram_we) ram_q[ram_addr] <= write_data;
  end
  io_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .en(rdy),
    .push(push),
    .din(write_data),
    .pop_ready(tx_ready),
    .thresh(AF_THRESH),
    .dout(tx_data),
    .valid(tx_valid),
    .count(fifo_count),
    .almost_full(io_buffer_full)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of RAM timing, IO FIFO, back-pressure, halt, rdy and reset.
module tb_mem_responder;
  logic clk, rst, rdy, is_write, tx_ready;
  logic [31:0] call_addr;
  logic [7:0] write_data;
  logic [7:0] ret_data, tx_data;
  logic io_buffer_full, tx_valid, sim_end, io_overflow;
  int checks, failures;

  mem_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .call_addr(call_addr), .is_write(is_write),
    .write_data(write_data), .ret_data(ret_data), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .sim_end(sim_end),
    .io_overflow(io_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    call_addr = a; is_write = 1'b1; write_data = d;
    tick();
    is_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    call_addr = a; is_write = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; is_write = 1'b0; call_addr = '0; write_data = '0; tx_ready = 1'b0;
    tick(); tick();
    checks++; if (ret_data !== 8'h00) begin failures++; $display("FAIL reset_ret_data got=%h exp=00", ret_data); end
    checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", io_buffer_full); end
    checks++; if (sim_end !== 1'b0) begin failures++; $display("FAIL reset_sim_end got=%b exp=0", sim_end); end
    checks++; if (io_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", io_overflow); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    rst = 1'b1;
  endtask

  task automatic test_ram();
    wr(32'h11, 8'h00);
    wr(32'h10, 8'hA5);
    rd(32'h10);
    checks++; if (ret_data !== 8'hA5) begin failures++; $display("FAIL ram_write_read got=%h exp=a5", ret_data); end
    rd(32'h11);
    checks++; if (ret_data !== 8'h00) begin failures++; $display("FAIL ram_read_zero got=%h exp=00", ret_data); end
    rd(32'h10);
    checks++; if (ret_data !== 8'hA5) begin failures++; $display("FAIL ram_reread got=%h exp=a5", ret_data); end
    rd(32'h30008);
    checks++; if (ret_data !== 8'h00) begin failures++; $display("FAIL io_read got=%h exp=00", ret_data); end
  endtask

  task automatic test_rdw();
    wr(32'h20, 8'h11);
    wr(32'h20, 8'h22);
    checks++; if (ret_data !== 8'h11) begin failures++; $display("FAIL rdw_old got=%h exp=11", ret_data); end
    rd(32'h20);
    checks++; if (ret_data !== 8'h22) begin failures++; $display("FAIL rdw_new got=%h exp=22", ret_data); end
  endtask

  task automatic test_io_drain();
    tx_ready = 1'b0;
    wr(32'h30000, 8'h48);
    checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL io_valid1 got=%b exp=1", tx_valid); end
    wr(32'h30000, 8'h69);
    checks++; if (tx_data !== 8'h48) begin failures++; $display("FAIL io_head got=%h exp=48", tx_data); end
    call_addr = 32'h0; tx_ready = 1'b1;
    #1;
    checks++; if (tx_data !== 8'h48) begin failures++; $display("FAIL io_drain0 got=%h exp=48", tx_data); end
    tick();
    checks++; if (tx_data !== 8'h69 || tx_valid !== 1'b1) begin failures++; $display("FAIL io_drain1 got=%h/%b exp=69/1", tx_data, tx_valid); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL io_drain_empty got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      wr(32'h30000, 8'(i));
      if (i == 5) begin
        checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL bp_full_at5 got=%b exp=0", io_buffer_full); end
      end
    end
    checks++; if (io_buffer_full !== 1'b1) begin failures++; $display("FAIL bp_full_at6 got=%b exp=1", io_buffer_full); end
    wr(32'h30000, 8'd7);
    wr(32'h30000, 8'd8);
    checks++; if (io_overflow !== 1'b0) begin failures++; $display("FAIL bp_no_overflow got=%b exp=0", io_overflow); end
    wr(32'h30000, 8'd9);
    checks++; if (io_overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b exp=1", io_overflow); end
    call_addr = 32'h0; tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin failures++; $display("FAIL bp_drain%0d got=%h/%b exp=%h/1", i, tx_data, tx_valid, 8'(i)); end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", tx_valid); end
    checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL bp_full_clear got=%b exp=0", io_buffer_full); end
    checks++; if (io_overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow_sticky got=%b exp=1", io_overflow); end
    tx_ready = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (io_overflow !== 1'b0) begin failures++; $display("FAIL bp_overflow_reset got=%b exp=0", io_overflow); end
  endtask

  task automatic test_simul();
    tx_ready = 1'b0;
    wr(32'h30000, 8'h10);
    wr(32'h30000, 8'h11);
    wr(32'h30000, 8'h12);
    call_addr = 32'h30000; is_write = 1'b1; write_data = 8'h13; tx_ready = 1'b1;
    #1;
    checks++; if (tx_data !== 8'h10) begin failures++; $display("FAIL sim_head got=%h exp=10", tx_data); end
    tick();
    is_write = 1'b0; call_addr = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h10 + i)) begin failures++; $display("FAIL sim_order%0d got=%h/%b exp=%h/1", i, tx_data, tx_valid, 8'(8'h10 + i)); end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL sim_count3 got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_wrap();
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      call_addr = 32'h30000; is_write = 1'b1; write_data = 8'(8'h40 + i);
      #1;
      if (i > 0) begin
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h40 + i - 1)) begin failures++; $display("FAIL wrap%0d got=%h/%b exp=%h/1", i, tx_data, tx_valid, 8'(8'h40 + i - 1)); end
      end
      tick();
    end
    is_write = 1'b0; call_addr = 32'h0;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h53) begin failures++; $display("FAIL wrap_last got=%h/%b exp=53/1", tx_data, tx_valid); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_halt();
    wr(32'h30004, 8'hFF);
    checks++; if (sim_end !== 1'b1) begin failures++; $display("FAIL halt_pulse got=%b exp=1", sim_end); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL halt_no_push got=%b exp=0", tx_valid); end
    rd(32'h0);
    checks++; if (sim_end !== 1'b0) begin failures++; $display("FAIL halt_one_cycle got=%b exp=0", sim_end); end
  endtask

  task automatic test_rdy();
    wr(32'h50, 8'h77);
    rd(32'h50);
    checks++; if (ret_data !== 8'h77) begin failures++; $display("FAIL rdy_pre got=%h exp=77", ret_data); end
    rdy = 1'b0;
    call_addr = 32'h50; is_write = 1'b1; write_data = 8'h99;
    tick();
    call_addr = 32'h30000;
    tick();
    call_addr = 32'h30004;
    tick();
    checks++; if (sim_end !== 1'b0) begin failures++; $display("FAIL rdy_no_halt got=%b exp=0", sim_end); end
    checks++; if (ret_data !== 8'h77) begin failures++; $display("FAIL rdy_hold got=%h exp=77", ret_data); end
    is_write = 1'b0; rdy = 1'b1;
    rd(32'h50);
    checks++; if (ret_data !== 8'h99 && ret_data !== 8'h77) begin failures++; $display("FAIL rdy_read got=%h exp=77", ret_data); end
    checks++; if (ret_data !== 8'h77) begin failures++; $display("FAIL rdy_ram_unchanged got=%h exp=77", ret_data); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rdy_no_push got=%b exp=0", tx_valid); end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 5; i++) wr(32'h30000, 8'(8'hC0 + i));
    checks++; if (tx_valid !== 1'b1 || io_buffer_full !== 1'b0) begin failures++; $display("FAIL mid_queued got=%b/%b exp=1/0", tx_valid, io_buffer_full); end
    rst = 1'b0; call_addr = 32'h30000; is_write = 1'b1; write_data = 8'hEE;
    tick();
    rst = 1'b1; is_write = 1'b0; call_addr = 32'h0;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", tx_valid); end
    checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL mid_reset_full got=%b exp=0", io_buffer_full); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL mid_inflight_dropped got=%b exp=0", tx_valid); end
    rd(32'h10);
    checks++; if (ret_data !== 8'hA5) begin failures++; $display("FAIL mid_ram_kept got=%h exp=a5", ret_data); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_ram();
    test_rdw();
    test_io_drain();
    test_backpressure();
    test_simul();
    test_wrap();
    test_halt();
    test_rdy();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the byte-serial memory bus driven by the CPU memory controller. Each cycle it accepts one address plus optional write strobe and data byte. It serves ordinary addresses from an on-chip byte RAM with one-cycle read latency. Writes to the IO window go into an output FIFO that drives the host/UART transmit side, and the FIFO produces the `io_buffer_full` back-pressure signal that the controller samples before every store byte.

## Interface
- `RAM_ADDR_BITS`, 17, byte RAM size 2^RAM_ADDR_BITS; address bits above this are ignored for RAM
- `FIFO_DEPTH`, 8, IO transmit FIFO entries; power of two, ≥4
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  synchronous reset, active-low (rst==0 resets on the edge)
- `rdy`  input  1  global enable; 0 freezes all state
- `call_addr`  input  32  byte address of this cycle's access
- `is_write`  input  1  1 = write `write_data` to `call_addr` this cycle
- `write_data`  input  8  write byte
- `ret_data`  output  8  read byte for the address presented on the previous edge
- `io_buffer_full`  output  1  registered back-pressure; controller must not issue a store byte while high
- `tx_data`  output  8  FIFO head byte
- `tx_valid`  output  1  FIFO non-empty and rdy
- `tx_ready`  input  1  consumer accepts head when tx_valid&&tx_ready
- `sim_end`  output  1  one-cycle pulse on a write to the halt address
- `io_overflow`  output  1  sticky; an IO write arrived while the FIFO was full

## Operation
- Address decode: `call_addr[17:16]==2'b11` selects the IO window. All other addresses select RAM at `call_addr[RAM_ADDR_BITS-1:0]`.
- RAM read: every enabled edge registers `ret_data <= ram[addr]`. Reads are unconditional and have no side effects. Read-during-write to the same address returns the old byte.
- RAM write: `is_write` and a non-IO address → `ram[addr] <= write_data` on the edge.
- IO read: `ret_data <= 8'h00`.
- IO write to 0x30000: push `write_data` into the FIFO. If the FIFO is full (count==FIFO_DEPTH), drop the byte and set `io_overflow`.
- IO write to 0x30004: pulse `sim_end` for one cycle. Nothing is pushed.
- Other IO writes are ignored.
- FIFO pop: on tx_valid&&tx_ready. Push and pop in the same cycle leave count unchanged. A push into an empty FIFO is visible on tx_data the next cycle; there is no bypass.
- `io_buffer_full` is registered: `full <= (next_count >= FIFO_DEPTH-2)`. The two-entry margin covers the one write already in flight from the controller's registered `is_write` plus the one it decides on the stale flag.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is one bit wider.

## Timing
- Reset (rst==0 at the edge):
  - outputs: `ret_data`=0, `io_buffer_full`=0, `sim_end`=0, `io_overflow`=0, `tx_valid`=0
  - FIFO pointers and count are zeroed
  - RAM contents are not cleared
- Reset mid-transfer discards FIFO contents. An in-flight write on the reset edge is ignored.
- Read latency: exactly one cycle. An address presented before edge N has its data on `ret_data` after edge N, held until edge N+1.
- Write latency: the RAM is updated at the presenting edge. A read of the same address on the following cycle returns the new byte.
- rdy==0:
  - no RAM write, no push, no pop
  - `ret_data`, `io_buffer_full` and `io_overflow` are held
  - `sim_end`=0 and `tx_valid`=0
- The FIFO has no state machine beyond the count. Status changes appear one edge after the causing push or pop.

## Structure
- Shared constants in the common const header: `IO_WIN` (2'b11), `IO_TX_ADDR` (32'h30000), `IO_HALT_ADDR` (32'h30004), and the byte/address widths already used by the memory controller.
- Sub-module `io_tx_fifo`: synchronous FIFO with push/pop, count, an almost-full threshold input, and data/valid outputs.
- The RAM array and address decode stay in `mem_responder`.

## Test plan
- Read latency and write-then-read: write 8'hA5 to 0x00010; next cycle read 0x00010 → `ret_data`==8'hA5 one edge later. Read 0x00011 (never written, preloaded 0) → 8'h00.
- Same-address read-during-write: ram[0x20]=8'h11; present write 8'h22 together with a read of 0x20 → `ret_data`==8'h11, then the next read → 8'h22.
- IO push and drain: with tx_ready=0, write 'H' and 'i' to 0x30000 → count 2, tx_data=8'h48. Raise tx_ready → tx_data sequence 8'h48 then 8'h69, after which tx_valid falls.
- Back-pressure and overflow, FIFO_DEPTH=8, tx_ready=0:
  - writes 1..6 → `io_buffer_full` rises after the 6th push (count 6)
  - pushes 7–8 are accepted
  - a 9th write is dropped and `io_overflow`=1 until reset
- Simultaneous push and pop at count 3 → count stays 3 and data order is preserved. Pointer wrap after 20 push/pop pairs keeps FIFO order.
- Halt, rdy, reset:
  - write to 0x30004 → `sim_end` high for exactly one cycle
  - rdy=0 during a write to RAM → RAM is unchanged
  - rst=0 with 5 bytes queued → tx_valid=0, `io_buffer_full`=0 on the next cycle
